// File: rtl/mem_stage_lsu.sv
// ----------------------------------------------------------------------------
// mem_stage_lsu
// Memory-access stage of the 5-stage RV32I pipeline. It sits between the
// EX/MEM and MEM/WB registers and does three things:
//   * formats loads and stores (size, sign extension, byte enables)
//   * runs the request/acknowledge handshake to a multi-cycle data memory
//   * stalls the front of the pipeline until the access completes
//
// Configuration macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses are trapped in IDLE
//               (misalign_out pulses, the bus is never touched)
//   undefined - misalign_out is tied low; low address bits are ignored
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   valid_in .. MemtoReg_in  EX/MEM register fields
//   dmem_*                   data-memory bus (req/we/addr/wdata/be out,
//                            ack/rdata in)
//   stall_out                hold PC, IF/ID and EX/MEM
//   bus_error_out            one-cycle pulse when an access times out
//   misalign_out             one-cycle pulse on a trapped misaligned access
//   *_out (remaining)        MEM/WB register inputs
//
// State | meaning
//   IDLE | no access in flight; non-memory ops pass straight through
//   BUS  | request on the bus, waiting for dmem_ack or timeout
//   DONE | one cycle presenting the finished result to MEM/WB
// ----------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [4:0]  rd_addr_in,
    input  logic        reg_write_en_in,
    input  logic        MemtoReg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic        bus_error_out,
    output logic        misalign_out,
    output logic        reg_write_en_out,
    output logic        MemtoReg_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] mem_read_data_out,
    output logic [4:0]  rd_addr_out
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t      r_state;
    logic        r_req, r_we, r_rwe, r_m2r, r_is_load, r_bus_error;
    logic [31:0] r_dmem_addr, r_wdata, r_addr, r_load_data;
    logic [3:0]  r_be;
    logic [7:0]  r_cnt;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;

    logic        w_mem_op, w_misalign, w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_cnt_next;

    // funct3[1:0] encodes the access size; 011/110/111 fall into the word case.
    function automatic logic [31:0] f_load(input logic [2:0]  f3,
                                           input logic [1:0]  lane,
                                           input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (f3[1:0])
            2'b00:   f_load = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   f_load = {{16{h[15] & ~f3[2]}}, h};
            default: f_load = d;
        endcase
    endfunction

    assign w_mem_op   = valid_in & (mem_read_in | mem_write_in);
    assign w_cnt_next = r_cnt + 8'd1;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = w_mem_op &
                        (((funct3_in[1:0] == 2'b01) & alu_result_in[0]) |
                         (funct3_in[1]              & (alu_result_in[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start = w_mem_op & ~w_misalign;

    // Store lane steering; loads always fetch the whole word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                w_wdata = {4{store_data_in[7:0]}};
                if (!mem_read_in) w_be = 4'b0001 << alu_result_in[1:0];
            end
            2'b01: begin
                w_wdata = {2{store_data_in[15:0]}};
                if (!mem_read_in) w_be = alu_result_in[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_dmem_addr <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_rwe       <= 1'b0;
            r_m2r       <= 1'b0;
            r_addr      <= '0;
            r_funct3    <= '0;
            r_is_load   <= 1'b0;
            r_load_data <= '0;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_rd        <= rd_addr_in;
                        r_rwe       <= reg_write_en_in;
                        r_m2r       <= MemtoReg_in;
                        r_addr      <= alu_result_in;
                        r_funct3    <= funct3_in;
                        r_is_load   <= mem_read_in;
                        r_req       <= 1'b1;
                        r_we        <= ~mem_read_in;
                        r_dmem_addr <= {alu_result_in[31:2], 2'b00};
                        r_be        <= w_be;
                        r_wdata     <= w_wdata;
                        r_cnt       <= '0;
                        r_load_data <= '0;
                        r_state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (dmem_ack) begin
                        r_load_data <= r_is_load ? f_load(r_funct3, r_addr[1:0], dmem_rdata) : 32'd0;
                        r_req       <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == TIMEOUT_LIMIT) begin
                            r_bus_error <= 1'b1;
                            r_req       <= 1'b0;
                            r_rwe       <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_bus_error <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output muxing: pass-through in IDLE, bubble while busy, latched in DONE.
    always_comb begin
        stall_out         = 1'b0;
        misalign_out      = 1'b0;
        reg_write_en_out  = 1'b0;
        MemtoReg_out      = MemtoReg_in;
        rd_addr_out       = rd_addr_in;
        alu_result_out    = alu_result_in;
        mem_read_data_out = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    misalign_out = w_misalign;
                    stall_out    = ~w_misalign;
                end else begin
                    reg_write_en_out = reg_write_en_in & valid_in;
                end
            end
            S_BUS: stall_out = 1'b1;
            S_DONE: begin
                reg_write_en_out  = r_rwe;
                MemtoReg_out      = r_m2r;
                rd_addr_out       = r_rd;
                alu_result_out    = r_addr;
                mem_read_data_out = r_load_data;
            end
            default: ;
        endcase
        // The FSM already sits in IDLE during reset; keep the pass-through quiet.
        if (rst) begin
            stall_out        = 1'b0;
            misalign_out     = 1'b0;
            reg_write_en_out = 1'b0;
        end
    end

    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_dmem_addr;
    assign dmem_wdata    = r_wdata;
    assign dmem_be       = r_be;
    assign bus_error_out = r_bus_error & ~rst;

endmodule
